pipe_stage_buf: RTL and testbench
=================================

# pipe_stage_buf

Parametrised pipeline stage buffer: the general replacement for the fixed IF/ID latch. It carries LANES instruction slots (PC, instruction word and exception code per lane) between two CPU pipeline stages. It uses a valid/ready handshake in place of a global stall vector and supports a synchronous flush on exception. An optional skid entry registers the backpressure path, so in_ready never depends combinationally on out_ready.

## Interface
- LANES, 1: instruction slots carried per beat (1 = single issue, 2 = dual issue).
- ADDR_W, 32: PC width per lane.
- INSTR_W, 32: instruction word width per lane.
- EXCEP_W, 6: exception-type width per lane.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset (asserted at 0).
- flush  in  1  synchronous kill of all held beats; driven by exception/redirect.
- in_valid  in  1  upstream beat present.
- in_ready  out  1  buffer accepts a beat this cycle.
- in_lane_mask  in  LANES  per-lane valid bits of the beat.
- in_pc  in  LANES*ADDR_W  lane i at bits [i*ADDR_W +: ADDR_W].
- in_instr  in  LANES*INSTR_W  same packing.
- in_excep  in  LANES*EXCEP_W  same packing.
- out_valid  out  1  beat presented downstream.
- out_ready  in  1  downstream consumes the beat.
- out_lane_mask, out_pc, out_instr, out_excep  out  widths as inputs  presented beat.
- stall_cnt  out  16  saturating count of backpressured cycles.

## Operation
- Transfer in: in_valid && in_ready on a clock edge. Transfer out: out_valid && out_ready on a clock edge.
- Beats leave in arrival order. None is dropped except by flush, and none is duplicated.
- Main entry drives the outputs. It loads when empty, or when its beat leaves in the same cycle as an incoming beat.
- Data, lane mask and excep travel together. The buffer never inspects lane contents.
- A beat with in_lane_mask = 0 is still a beat and is passed through unchanged.
- flush = 1 at an edge:
  - out_valid and the skid entry are cleared.
  - out_lane_mask, out_pc, out_instr and out_excep are set to 0, so the bubble decodes as a NOP.
  - Any concurrent input transfer is discarded.
  - Flush dominates every other event.
- When out_valid falls without flush, the output data holds its last value and only out_valid goes to 0.
- stall_cnt increments on each edge where out_valid && !out_ready and saturates at 16'hFFFF. It is cleared only by reset; flush does not clear it.
- Reset (rst = 0, asynchronous): out_valid = 0, all data outputs = 0, skid empty, stall_cnt = 0, in_ready = 1. Input transfers are ignored while rst = 0. Normal operation starts on the first edge after rst returns to 1.

## Timing
- Latency: 1 cycle from input transfer to out_valid when the buffer is empty.
- Throughput: 1 beat per cycle while out_ready stays high.
- Without the skid entry: in_ready = !out_valid || out_ready, combinational from out_ready.
- With the skid entry: in_ready = skid empty, registered.
  - An input accepted while the main entry is held (out_valid && !out_ready) goes to the skid entry.
  - in_ready drops on the next cycle.
  - When out_ready next rises, the skid beat moves to main, and in_ready returns high the following cycle.
- Simultaneous input and output transfer on a full main entry with empty skid: the new beat replaces main directly and the skid stays empty.
- Flush together with out_ready: the departing beat counts as consumed; everything else is cleared.

## Configuration
- PIPE_STAGE_SKID_EN defined: the skid entry is instantiated, in_ready is registered, and capacity is 2 beats.
- PIPE_STAGE_SKID_EN undefined: there is no skid entry, in_ready is combinational, and capacity is 1 beat.
- The ordering, flush, reset and stall_cnt rules are identical in both builds.

## Structure
- The shared defines package supplies ADDR_W / INSTR_W / EXCEP_W defaults, matching INST_ADDR_BUS, INST_BUS and EXCEP_TYPE_BUS. It also supplies the lane-slice packing macro and the stall-counter width constant.
- Sub-module pipe_skid_entry: a single registered beat with load/clear/valid and no handshake logic. It is instantiated once for main and, under PIPE_STAGE_SKID_EN, once for skid.

## Test plan
- Reset then stream: assert rst = 0 mid-stream, release, send pc = 0xBFC00000/0xBFC00004/0xBFC00008 with out_ready = 1. Required: out_valid = 0 and outputs 0 during reset; beats appear 1 cycle after each input, in order, one per cycle.
- Backpressure: hold out_ready = 0 for 5 cycles with continuous input. Required: skid build accepts exactly 2 beats, no-skid build accepts 1; stall_cnt = 5; release delivers beats in order, none lost.
- Flush collision: flush = 1 in the same cycle as in_valid with instr 0x24020001. Required: next cycle out_valid = 0, out_instr = 0, out_excep = 0; the beat never appears.
- Dual lane: LANES = 2, in_lane_mask = 2'b10, excep lane1 = 6'h0C. Required: out_lane_mask = 2'b10 and the lane1 excep field = 6'h0C, with no lane crosstalk.
- Saturation: hold a beat with out_ready = 0 for 70000 cycles. Required: stall_cnt sticks at 0xFFFF; a following flush leaves it at 0xFFFF.
- Pass-through: in_ready = 1 and out_ready = 1 every cycle for 100 random beats. Required: the output sequence equals the input sequence and no bubbles are inserted.

Source files
------------

// File: rtl/pipe_stage_buf_pkg.sv
// pipe_stage_buf_pkg
// Shared definitions for the pipeline stage buffer slice.
//   INST_ADDR_BUS / INST_BUS / EXCEP_TYPE_BUS : default per-lane field widths
//   STALL_CNT_W / STALL_CNT_MAX               : width and ceiling of the stall counter
//   sat_inc()                                 : saturating increment for the stall counter
//   `PIPE_LANE_SLICE(lane, width)             : part-select of one lane in a packed lane bus
`ifndef PIPE_STAGE_BUF_PKG_SV
`define PIPE_STAGE_BUF_PKG_SV

`define PIPE_LANE_SLICE(lane, width) [(lane)*(width) +: (width)]

package pipe_stage_buf_pkg;

  localparam int INST_ADDR_BUS  = 32;
  localparam int INST_BUS       = 32;
  localparam int EXCEP_TYPE_BUS = 6;

  localparam int STALL_CNT_W = 16;
  localparam logic [STALL_CNT_W-1:0] STALL_CNT_MAX = '1;

  function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] value);
    return (value == STALL_CNT_MAX) ? value : value + 1'b1;
  endfunction

endpackage

`endif

// File: rtl/pipe_skid_entry.sv
// pipe_skid_entry
// One registered beat with a valid flag. It carries no handshake logic; the
// owner decides when to load, clear or drop it.
//   clk, rst : clock and asynchronous active-low reset
//   clear    : zero the data and the valid flag (highest priority)
//   load     : capture d and set valid
//   drop     : clear valid only, keeping the data visible
//   d / q    : beat in / beat held
//   valid    : entry holds a live beat
module pipe_skid_entry #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         load,
  input  logic         drop,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end else if (drop) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf
// Pipeline stage buffer carrying LANES instruction slots (lane mask, PC,
// instruction word, exception code) between two CPU stages with a
// valid/ready handshake and a synchronous flush.
//
// Build option: define PIPE_STAGE_SKID_EN to add a second (skid) entry. That
// makes in_ready a registered signal (skid empty) and raises capacity to two
// beats. Without it, in_ready = !out_valid || out_ready and capacity is one.
//
// Ports
//   clk, rst        : clock, asynchronous active-low reset
//   flush           : kills every held beat and any concurrent input beat
//   in_valid/ready  : upstream handshake
//   in_lane_mask, in_pc, in_instr, in_excep    : incoming beat, lane i at [i*W +: W]
//   out_valid/ready : downstream handshake
//   out_lane_mask, out_pc, out_instr, out_excep : presented beat
//   stall_cnt       : saturating count of edges with out_valid && !out_ready
module pipe_stage_buf
  import pipe_stage_buf_pkg::*;
#(
  parameter int LANES   = 1,
  parameter int ADDR_W  = INST_ADDR_BUS,
  parameter int INSTR_W = INST_BUS,
  parameter int EXCEP_W = EXCEP_TYPE_BUS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES-1:0]         in_lane_mask,
  input  logic [LANES*ADDR_W-1:0]  in_pc,
  input  logic [LANES*INSTR_W-1:0] in_instr,
  input  logic [LANES*EXCEP_W-1:0] in_excep,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES-1:0]         out_lane_mask,
  output logic [LANES*ADDR_W-1:0]  out_pc,
  output logic [LANES*INSTR_W-1:0] out_instr,
  output logic [LANES*EXCEP_W-1:0] out_excep,
  output logic [STALL_CNT_W-1:0]   stall_cnt
);

  // The whole beat is moved as one opaque vector; lanes are never inspected.
  localparam int BEAT_W = LANES * (1 + ADDR_W + INSTR_W + EXCEP_W);

  logic [BEAT_W-1:0] in_beat;
  logic [BEAT_W-1:0] main_d;
  logic [BEAT_W-1:0] main_q;
  logic              main_valid;
  logic              main_load;
  logic              main_drop;
  logic              in_fire;
  logic              out_fire;

  assign in_beat  = {in_lane_mask, in_pc, in_instr, in_excep};
  assign {out_lane_mask, out_pc, out_instr, out_excep} = main_q;
  assign out_valid = main_valid;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = main_valid && out_ready;

`ifdef PIPE_STAGE_SKID_EN
  logic              skid_valid;
  logic              skid_load;
  logic              skid_drop;
  logic [BEAT_W-1:0] skid_q;

  // in_ready comes straight from a flop, cutting the combinational path
  // from out_ready back upstream.
  assign in_ready = !skid_valid;

  // A full skid entry blocks input, so it only ever refills main. With the
  // skid empty, a new beat goes into main whenever main is free or leaving
  // this cycle, and parks in the skid only when main is held.
  always_comb begin
    main_d    = in_beat;
    main_load = 1'b0;
    main_drop = 1'b0;
    skid_load = 1'b0;
    skid_drop = 1'b0;
    if (skid_valid) begin
      if (out_fire) begin
        main_d    = skid_q;
        main_load = 1'b1;
        skid_drop = 1'b1;
      end
    end else if (in_fire) begin
      if (!main_valid || out_ready) begin
        main_load = 1'b1;
      end else begin
        skid_load = 1'b1;
      end
    end else if (out_fire) begin
      main_drop = 1'b1;
    end
  end

  pipe_skid_entry #(
    .W(BEAT_W)
  ) u_skid (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .load  (skid_load),
    .drop  (skid_drop),
    .d     (in_beat),
    .valid (skid_valid),
    .q     (skid_q)
  );
`else
  assign in_ready = !main_valid || out_ready;

  // Single entry: an accepted beat always lands in main, possibly replacing
  // the beat that leaves on the same edge.
  always_comb begin
    main_d    = in_beat;
    main_load = in_fire;
    main_drop = out_fire && !in_fire;
  end
`endif

  // Flush clears main to all zeros so the bubble decodes as a NOP, and it
  // overrides any load on the same edge.
  pipe_skid_entry #(
    .W(BEAT_W)
  ) u_main (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .load  (main_load),
    .drop  (main_drop),
    .d     (main_d),
    .valid (main_valid),
    .q     (main_q)
  );

  // Counts backpressured edges, including one that coincides with a flush;
  // only reset clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (main_valid && !out_ready) begin
      stall_cnt <= sat_inc(stall_cnt);
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf
// Scoreboard bench for pipe_stage_buf with LANES = 2. The driver pushes each
// accepted beat into a queue; an independent monitor pops and compares every
// beat that leaves the buffer. Directed checks cover reset, latency, hold,
// backpressure, flush, lane separation, pass-through and counter saturation.
// Works for both builds (with or without PIPE_STAGE_SKID_EN).
module tb_pipe_stage_buf;

  localparam int LANES = 2;
  localparam int AW    = 32;
  localparam int IW    = 32;
  localparam int EW    = 6;

`ifdef PIPE_STAGE_SKID_EN
  localparam int CAPACITY = 2;
`else
  localparam int CAPACITY = 1;
`endif

  typedef struct packed {
    logic [LANES-1:0]    mask;
    logic [LANES*AW-1:0] pc;
    logic [LANES*IW-1:0] instr;
    logic [LANES*EW-1:0] excep;
  } beat_t;

  logic                clk = 1'b0;
  logic                rst;
  logic                flush;
  logic                in_valid;
  logic                in_ready;
  logic [LANES-1:0]    in_lane_mask;
  logic [LANES*AW-1:0] in_pc;
  logic [LANES*IW-1:0] in_instr;
  logic [LANES*EW-1:0] in_excep;
  logic                out_valid;
  logic                out_ready;
  logic [LANES-1:0]    out_lane_mask;
  logic [LANES*AW-1:0] out_pc;
  logic [LANES*IW-1:0] out_instr;
  logic [LANES*EW-1:0] out_excep;
  logic [15:0]         stall_cnt;

  beat_t sb[$];
  beat_t monExp;
  int    errors    = 0;
  int    checks    = 0;
  int    delivered = 0;

  pipe_stage_buf #(
    .LANES   (LANES),
    .ADDR_W  (AW),
    .INSTR_W (IW),
    .EXCEP_W (EW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_lane_mask  (in_lane_mask),
    .in_pc         (in_pc),
    .in_instr      (in_instr),
    .in_excep      (in_excep),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_lane_mask (out_lane_mask),
    .out_pc        (out_pc),
    .out_instr     (out_instr),
    .out_excep     (out_excep),
    .stall_cnt     (stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic beat_t mkBeat(input logic [1:0] m, input logic [31:0] pc0, input logic [31:0] pc1,
                                   input logic [31:0] i0, input logic [31:0] i1,
                                   input logic [5:0] e0, input logic [5:0] e1);
    beat_t b;
    b.mask  = m;
    b.pc    = {pc1, pc0};
    b.instr = {i1, i0};
    b.excep = {e1, e0};
    return b;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock cycle of stimulus, entered and left at posedge+1. A beat is
  // recorded as accepted when in_valid && in_ready holds before the edge and
  // no flush is pending; a flush empties the scoreboard at that edge.
  task automatic applyStimulus(input beat_t b, input logic v, input logic fl, input logic ordy,
                               output logic acc);
    in_valid     = v;
    flush        = fl;
    out_ready    = ordy;
    in_lane_mask = b.mask;
    in_pc        = b.pc;
    in_instr     = b.instr;
    in_excep     = b.excep;
    @(negedge clk);
    acc = v && in_ready && !fl && rst;
    @(posedge clk);
    if (fl) sb.delete();
    else if (acc) sb.push_back(b);
    #1;
  endtask

  // Monitor: a beat leaves on the coming edge whenever out_valid && out_ready.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      delivered++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_beat: got pc 0x%0h, expected no beat", out_pc);
      end else begin
        monExp = sb.pop_front();
        checkOutput("beat_mask",  64'(out_lane_mask), 64'(monExp.mask));
        checkOutput("beat_pc",    64'(out_pc),        64'(monExp.pc));
        checkOutput("beat_instr", 64'(out_instr),     64'(monExp.instr));
        checkOutput("beat_excep", 64'(out_excep),     64'(monExp.excep));
      end
    end
  end

  // Watchdog so the run always ends even if the stimulus gets stuck.
  initial begin
    #5_000_000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    beat_t zeroBeat;
    beat_t bp [4];
    beat_t b;
    logic  acc;
    int    idx;
    int    accCount;
    int    validCount;
    int    base;

    zeroBeat = '0;
    rst = 1'b0; flush = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
    b = mkBeat(2'b01, 32'h5555_0000, 32'h6666_0000, 32'h1, 32'h2, 6'h1, 6'h2);
    in_lane_mask = b.mask; in_pc = b.pc; in_instr = b.instr; in_excep = b.excep;

    // Reset state with input activity ignored
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_out_pc",    64'(out_pc),    64'd0);
    checkOutput("reset_out_instr", 64'(out_instr), 64'd0);
    checkOutput("reset_in_ready",  64'(in_ready),  64'd1);
    checkOutput("reset_stall_cnt", 64'(stall_cnt), 64'd0);
    in_valid = 1'b0;
    rst = 1'b1;
    applyStimulus(zeroBeat, 1'b0, 1'b0, 1'b1, acc);
    checkOutput("post_reset_idle", 64'(out_valid), 64'd0);

    // Reset asserted while a beat is held
    applyStimulus(mkBeat(2'b01, 32'h1111_0000, 32'h2222_0000, 32'h3, 32'h4, 6'h3, 6'h4),
                  1'b1, 1'b0, 1'b0, acc);
    checkOutput("held_out_valid", 64'(out_valid), 64'd1);
    applyStimulus(zeroBeat, 1'b0, 1'b0, 1'b0, acc);
    #2 rst = 1'b0;
    #1;
    checkOutput("midreset_out_valid", 64'(out_valid),     64'd0);
    checkOutput("midreset_out_pc",    64'(out_pc),        64'd0);
    checkOutput("midreset_out_excep", 64'(out_excep),     64'd0);
    checkOutput("midreset_out_mask",  64'(out_lane_mask), 64'd0);
    checkOutput("midreset_stall_cnt", 64'(stall_cnt),     64'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Streaming with one-cycle latency and no bubbles
    for (int k = 0; k < 3; k++) begin
      applyStimulus(mkBeat(2'b01, 32'hBFC0_0000 + 32'(4 * k), 32'hDEAD_0000 + 32'(k),
                           32'h2000_0000 + 32'(k), 32'h3000_0000 + 32'(k), 6'(k), 6'h3F),
                    1'b1, 1'b0, 1'b1, acc);
      checkOutput("stream_accept",    64'(acc),          64'd1);
      checkOutput("stream_out_valid", 64'(out_valid),    64'd1);
      checkOutput("stream_out_pc0",   64'(out_pc[31:0]), 64'hBFC0_0000 + 64'(4 * k));
    end
    applyStimulus(zeroBeat, 1'b0, 1'b0, 1'b1, acc);
    checkOutput("drain_out_valid", 64'(out_valid),    64'd0);
    checkOutput("drain_hold_pc0",  64'(out_pc[31:0]), 64'hBFC0_0008);
    checkOutput("stream_stall",    64'(stall_cnt),    64'd0);

    // Backpressure: one load edge then five stalled edges
    for (int k = 0; k < 4; k++) begin
      bp[k] = mkBeat(2'b01, 32'h0000_1000 + 32'(4 * k), 32'h0, 32'h4000_0000 + 32'(k), 32'h0, 6'h0, 6'h0);
    end
    idx = 0;
    accCount = 0;
    for (int c = 0; c < 6; c++) begin
      applyStimulus(bp[idx], 1'b1, 1'b0, 1'b0, acc);
      if (acc) begin
        idx++;
        accCount++;
      end
    end
    checkOutput("bp_accepted",  64'(accCount),  64'(CAPACITY));
    checkOutput("bp_stall_cnt", 64'(stall_cnt), 64'd5);
    checkOutput("bp_in_ready",  64'(in_ready),  64'd0);
    base = delivered;
    for (int c = 0; c < 20; c++) begin
      if (idx >= 4 && sb.size() == 0 && !out_valid) break;
      if (idx < 4) begin
        applyStimulus(bp[idx], 1'b1, 1'b0, 1'b1, acc);
        if (acc) idx++;
      end else begin
        applyStimulus(zeroBeat, 1'b0, 1'b0, 1'b1, acc);
      end
    end
    checkOutput("bp_delivered",     64'(delivered - base), 64'd4);
    checkOutput("bp_sb_empty",      64'(sb.size()),        64'd0);
    checkOutput("bp_stall_release", 64'(stall_cnt),        64'd5);

    // Flush collides with an incoming beat while the buffer is full
    applyStimulus(mkBeat(2'b01, 32'h0000_2000, 32'h0, 32'h1111_2222, 32'h0, 6'h05, 6'h0),
                  1'b1, 1'b0, 1'b0, acc);
    applyStimulus(mkBeat(2'b01, 32'h0000_2004, 32'h0, 32'h3333_4444, 32'h0, 6'h06, 6'h0),
                  1'b1, 1'b0, 1'b0, acc);
    applyStimulus(mkBeat(2'b01, 32'hBFC0_0200, 32'h0, 32'h2402_0001, 32'h0, 6'h0, 6'h0),
                  1'b1, 1'b1, 1'b0, acc);
    checkOutput("flush_out_valid", 64'(out_valid),     64'd0);
    checkOutput("flush_out_instr", 64'(out_instr),     64'd0);
    checkOutput("flush_out_excep", 64'(out_excep),     64'd0);
    checkOutput("flush_out_pc",    64'(out_pc),        64'd0);
    checkOutput("flush_out_mask",  64'(out_lane_mask), 64'd0);
    checkOutput("flush_in_ready",  64'(in_ready),      64'd1);
    checkOutput("flush_stall_cnt", 64'(stall_cnt),     64'd7);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(zeroBeat, 1'b0, 1'b0, 1'b1, acc);
      checkOutput("flush_no_ghost", 64'(out_valid), 64'd0);
    end

    // Flush together with out_ready: the departing beat is still delivered
    applyStimulus(mkBeat(2'b01, 32'h0000_3000, 32'h0, 32'h5555_6666, 32'h0, 6'h0, 6'h0),
                  1'b1, 1'b0, 1'b1, acc);
    base = delivered;
    applyStimulus(zeroBeat, 1'b0, 1'b1, 1'b1, acc);
    checkOutput("flushrdy_delivered", 64'(delivered - base), 64'd1);
    checkOutput("flushrdy_out_valid", 64'(out_valid),        64'd0);

    // Dual lane: only lane 1 valid, with an exception code on lane 1
    applyStimulus(mkBeat(2'b10, 32'h0, 32'hBFC0_0104, 32'h0, 32'h8C43_0000, 6'h0, 6'h0C),
                  1'b1, 1'b0, 1'b1, acc);
    checkOutput("dual_mask",   64'(out_lane_mask),   64'h2);
    checkOutput("dual_excep1", 64'(out_excep[11:6]), 64'h0C);
    checkOutput("dual_excep0", 64'(out_excep[5:0]),  64'h0);
    checkOutput("dual_pc1",    64'(out_pc[63:32]),   64'hBFC0_0104);
    checkOutput("dual_pc0",    64'(out_pc[31:0]),    64'h0);

    // Empty lane mask is still a beat
    applyStimulus(mkBeat(2'b00, 32'h0000_1234, 32'h0000_5678, 32'h9, 32'hA, 6'h1, 6'h2),
                  1'b1, 1'b0, 1'b1, acc);
    checkOutput("nomask_out_valid", 64'(out_valid),     64'd1);
    checkOutput("nomask_mask",      64'(out_lane_mask), 64'd0);
    checkOutput("nomask_pc0",       64'(out_pc[31:0]),  64'h1234);

    // Pass-through of 100 beats at full rate
    accCount = 0;
    validCount = 0;
    for (int k = 0; k < 100; k++) begin
      b = mkBeat(2'($urandom_range(0, 3)), $urandom, $urandom, $urandom, $urandom,
                 6'($urandom), 6'($urandom));
      applyStimulus(b, 1'b1, 1'b0, 1'b1, acc);
      if (acc) accCount++;
      if (out_valid) validCount++;
    end
    applyStimulus(zeroBeat, 1'b0, 1'b0, 1'b1, acc);
    checkOutput("pass_accepted", 64'(accCount),   64'd100);
    checkOutput("pass_no_bubble", 64'(validCount), 64'd100);
    checkOutput("pass_sb_empty", 64'(sb.size()),  64'd0);
    checkOutput("pass_stall_cnt", 64'(stall_cnt), 64'd7);

    // Saturation of the stall counter, then flush leaves it saturated
    applyStimulus(mkBeat(2'b01, 32'h0000_7000, 32'h0, 32'h7, 32'h0, 6'h0, 6'h0),
                  1'b1, 1'b0, 1'b0, acc);
    in_valid = 1'b0;
    repeat (70000) @(posedge clk);
    #1;
    checkOutput("sat_stall_cnt", 64'(stall_cnt), 64'hFFFF);
    checkOutput("sat_out_valid", 64'(out_valid), 64'd1);
    applyStimulus(zeroBeat, 1'b0, 1'b1, 1'b0, acc);
    checkOutput("sat_after_flush",     64'(stall_cnt), 64'hFFFF);
    checkOutput("sat_flush_out_valid", 64'(out_valid), 64'd0);

    applyStimulus(zeroBeat, 1'b0, 1'b0, 1'b1, acc);
    checkOutput("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
